// File: rtl/score_pkg.sv
// Shared encodings and default constants for the score engine.
package score_pkg;

  localparam int          SCORE_W        = 32;
  localparam int          COMBO_W        = 16;
  localparam int unsigned SCORE_MAX_8DIG = 32'd99999999;

  typedef enum logic [1:0] {
    GRADE_MISS    = 2'd0,
    GRADE_GOOD    = 2'd1,
    GRADE_GREAT   = 2'd2,
    GRADE_PERFECT = 2'd3
  } grade_e;

  typedef enum logic [1:0] {
    PHASE_IDLE     = 2'd0,
    PHASE_PLAYING  = 2'd1,
    PHASE_FINISHED = 2'd2
  } phase_e;

endpackage

// File: rtl/score_keeper_if.sv
// Game-event inputs and score/status outputs of score_keeper.
interface score_keeper_if;
  import score_pkg::*;

  logic               GAME_START;
  logic               GAME_END;
  logic               HIT_VALID;
  logic [1:0]         HIT_GRADE;
  logic [SCORE_W-1:0] BINARY_SCORE;
  logic [COMBO_W-1:0] COMBO;
  logic [COMBO_W-1:0] MAX_COMBO;
  logic [SCORE_W-1:0] HIGH_SCORE;
  logic               NEW_RECORD;
  logic               SATURATED;
  logic [1:0]         PHASE;

  modport master (
    output GAME_START, GAME_END, HIT_VALID, HIT_GRADE,
    input  BINARY_SCORE, COMBO, MAX_COMBO, HIGH_SCORE, NEW_RECORD, SATURATED, PHASE
  );

  modport slave (
    input  GAME_START, GAME_END, HIT_VALID, HIT_GRADE,
    output BINARY_SCORE, COMBO, MAX_COMBO, HIGH_SCORE, NEW_RECORD, SATURATED, PHASE
  );

endinterface

// File: rtl/score_sat_adder.sv
// Combinational 33-bit add with clamp to SCORE_MAX; clamp_o flags that the ceiling was reached.
module score_sat_adder
  import score_pkg::*;
#(
  parameter int unsigned SCORE_MAX = SCORE_MAX_8DIG
) (
  input  logic [SCORE_W-1:0] a_i,
  input  logic [SCORE_W-1:0] b_i,
  output logic [SCORE_W-1:0] sum_o,
  output logic               clamp_o
);

  localparam logic [SCORE_W:0] MAX_EXT = (SCORE_W + 1)'(SCORE_MAX);

  logic [SCORE_W:0] raw;

  assign raw = {1'b0, a_i} + {1'b0, b_i};

  always_comb begin
    sum_o   = raw[SCORE_W-1:0];
    clamp_o = 1'b0;
    if (raw >= MAX_EXT) begin
      sum_o   = SCORE_MAX;
      clamp_o = 1'b1;
    end
  end

endmodule

// File: rtl/score_keeper.sv
// Score engine: judged hits -> combo/multiplier (stage 1) -> saturating score add (stage 2),
// with game-phase FSM and a one-shot high-score compare once a finished round drains.
module score_keeper
  import score_pkg::*;
#(
  parameter int unsigned PTS_GOOD    = 100,
  parameter int unsigned PTS_GREAT   = 200,
  parameter int unsigned PTS_PERFECT = 300,
  parameter int unsigned COMBO_STEP  = 10,
  parameter int unsigned MAX_MULT    = 4,
  parameter int unsigned SCORE_MAX   = SCORE_MAX_8DIG
) (
  input logic           CLK,
  input logic           RST,
  score_keeper_if.slave sk
);

  phase_e             phase_q, phase_d;
  logic               accept, drained;
  logic [COMBO_W-1:0] combo_q, combo_d;
  logic [COMBO_W-1:0] max_combo_q, max_combo_d;
  logic [COMBO_W-1:0] step_cnt;
  logic [2:0]         mult;
  logic [SCORE_W-1:0] base_pts;
  logic               s1_vld_q;
  logic [SCORE_W-1:0] s1_pts_q, s1_pts_d;
  logic               s2_vld_q;
  logic [SCORE_W-1:0] score_q, score_sum;
  logic               score_clamp;
  logic               sat_q;
  logic [SCORE_W-1:0] high_q;
  logic               new_rec_q;
  logic               cmp_done_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) phase_q <= PHASE_IDLE;
    else      phase_q <= phase_d;
  end

  // GAME_START wins over GAME_END and restarts from any phase.
  always_comb begin
    phase_d = phase_q;
    accept  = 1'b0;
    drained = 1'b0;
    if (sk.GAME_START) begin
      phase_d = PHASE_PLAYING;
    end else begin
      if (sk.GAME_END && phase_q == PHASE_PLAYING) phase_d = PHASE_FINISHED;
      accept  = sk.HIT_VALID && (phase_q == PHASE_PLAYING);
      drained = (phase_q == PHASE_FINISHED) && !s1_vld_q && !s2_vld_q && !cmp_done_q;
    end
  end

  always_comb begin
    step_cnt = combo_q / COMBO_W'(COMBO_STEP);
    if (32'(step_cnt) + 32'd1 >= MAX_MULT) mult = 3'(MAX_MULT);
    else                                   mult = 3'(step_cnt + 16'd1);

    case (sk.HIT_GRADE)
      GRADE_GOOD:    base_pts = SCORE_W'(PTS_GOOD);
      GRADE_GREAT:   base_pts = SCORE_W'(PTS_GREAT);
      GRADE_PERFECT: base_pts = SCORE_W'(PTS_PERFECT);
      default:       base_pts = '0;
    endcase
    s1_pts_d = base_pts * SCORE_W'(mult);

    if (sk.HIT_GRADE == GRADE_MISS) combo_d = '0;
    else if (&combo_q)              combo_d = combo_q;
    else                            combo_d = combo_q + 16'd1;
    max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
  end

  // Stage 1: register weighted points and update combo on the accepting edge.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s1_vld_q    <= 1'b0;
      s1_pts_q    <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
    end else if (sk.GAME_START) begin
      s1_vld_q    <= 1'b0;
      s1_pts_q    <= '0;
      combo_q     <= '0;
      max_combo_q <= '0;
    end else begin
      s1_vld_q <= accept;
      if (accept) begin
        s1_pts_q    <= s1_pts_d;
        combo_q     <= combo_d;
        max_combo_q <= max_combo_d;
      end
    end
  end

  score_sat_adder #(.SCORE_MAX(SCORE_MAX)) u_add (
    .a_i     (score_q),
    .b_i     (s1_pts_q),
    .sum_o   (score_sum),
    .clamp_o (score_clamp)
  );

  // Stage 2: commit the saturating sum into the running score.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      s2_vld_q <= 1'b0;
      score_q  <= '0;
      sat_q    <= 1'b0;
    end else if (sk.GAME_START) begin
      s2_vld_q <= 1'b0;
      score_q  <= '0;
      sat_q    <= 1'b0;
    end else begin
      s2_vld_q <= s1_vld_q;
      if (s1_vld_q) begin
        score_q <= score_sum;
        if (score_clamp) sat_q <= 1'b1;
      end
    end
  end

  // Round close: compare exactly once after the finished round has fully drained.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      high_q     <= '0;
      new_rec_q  <= 1'b0;
      cmp_done_q <= 1'b0;
    end else if (sk.GAME_START) begin
      new_rec_q  <= 1'b0;
      cmp_done_q <= 1'b0;
    end else if (drained) begin
      cmp_done_q <= 1'b1;
      if (score_q > high_q) begin
        high_q    <= score_q;
        new_rec_q <= 1'b1;
      end
    end
  end

  assign sk.BINARY_SCORE = score_q;
  assign sk.COMBO        = combo_q;
  assign sk.MAX_COMBO    = max_combo_q;
  assign sk.HIGH_SCORE   = high_q;
  assign sk.NEW_RECORD   = new_rec_q;
  assign sk.SATURATED    = sat_q;
  assign sk.PHASE        = phase_q;

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: vector table, directed corner sequences, and random play vs. a round model.
module tb_score_keeper;
  import score_pkg::*;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  score_keeper_if if1 ();
  score_keeper_if if2 ();

  score_keeper u_dut1 (.CLK(CLK), .RST(RST), .sk(if1.slave));
  score_keeper #(.SCORE_MAX(1000)) u_dut2 (.CLK(CLK), .RST(RST), .sk(if2.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Round model: per-edge rules on plain integers; hits land in the score one edge after acceptance.
  longint smax[2] = '{99999999, 1000};
  int     m_phase[2], m_combo[2], m_maxc[2], m_nr[2], m_sat[2], m_done[2];
  int     m_pend[2], m_last_commit[2];
  longint m_score[2], m_high[2], m_pts[2];
  int     ecnt = 0;

  function automatic int grade_pts(input int g);
    case (g)
      1: return 100;
      2: return 200;
      3: return 300;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_phase[k] = 0; m_combo[k] = 0; m_maxc[k] = 0; m_nr[k] = 0; m_sat[k] = 0;
      m_done[k] = 0; m_pend[k] = 0; m_last_commit[k] = -10;
      m_score[k] = 0; m_high[k] = 0; m_pts[k] = 0;
    end
  endtask

  task automatic model_step(input int k, input int st, input int en, input int hv, input int g);
    int     drained_now, mult;
    longint s;
    if (st != 0) begin
      m_phase[k] = 1; m_combo[k] = 0; m_maxc[k] = 0; m_nr[k] = 0; m_sat[k] = 0;
      m_done[k] = 0; m_pend[k] = 0; m_last_commit[k] = -10; m_score[k] = 0;
      return;
    end
    drained_now = (m_phase[k] == 2 && m_done[k] == 0 && m_pend[k] == 0 &&
                   m_last_commit[k] != ecnt - 1) ? 1 : 0;
    if (m_pend[k] != 0) begin
      s = m_score[k] + m_pts[k];
      if (s >= smax[k]) begin s = smax[k]; m_sat[k] = 1; end
      m_score[k] = s;
      m_last_commit[k] = ecnt;
      m_pend[k] = 0;
    end
    if (drained_now != 0) begin
      m_done[k] = 1;
      if (m_score[k] > m_high[k]) begin m_high[k] = m_score[k]; m_nr[k] = 1; end
    end
    if (hv != 0 && m_phase[k] == 1) begin
      mult = 1 + m_combo[k] / 10;
      if (mult > 4) mult = 4;
      m_pts[k]  = grade_pts(g) * mult;
      m_pend[k] = 1;
      if (g == 0) m_combo[k] = 0;
      else if (m_combo[k] < 65535) m_combo[k] = m_combo[k] + 1;
      if (m_combo[k] > m_maxc[k]) m_maxc[k] = m_combo[k];
    end
    if (en != 0 && m_phase[k] == 1) m_phase[k] = 2;
  endtask

  task automatic drive(input int st, input int en, input int hv, input int g);
    @(negedge CLK);
    if1.GAME_START = 1'(st); if1.GAME_END = 1'(en); if1.HIT_VALID = 1'(hv); if1.HIT_GRADE = 2'(g);
    if2.GAME_START = 1'(st); if2.GAME_END = 1'(en); if2.HIT_VALID = 1'(hv); if2.HIT_GRADE = 2'(g);
    @(posedge CLK);
    ecnt++;
    model_step(0, st, en, hv, g);
    model_step(1, st, en, hv, g);
    #1;
  endtask

  task automatic get_out(input int k, output longint sc, output longint cb, output longint mc,
                         output longint hs, output longint nr, output longint sat, output longint ph);
    if (k == 0) begin
      sc = if1.BINARY_SCORE; cb = if1.COMBO; mc = if1.MAX_COMBO; hs = if1.HIGH_SCORE;
      nr = if1.NEW_RECORD; sat = if1.SATURATED; ph = if1.PHASE;
    end else begin
      sc = if2.BINARY_SCORE; cb = if2.COMBO; mc = if2.MAX_COMBO; hs = if2.HIGH_SCORE;
      nr = if2.NEW_RECORD; sat = if2.SATURATED; ph = if2.PHASE;
    end
  endtask

  task automatic check_zero(input string tag, input int k);
    longint sc, cb, mc, hs, nr, sat, ph;
    get_out(k, sc, cb, mc, hs, nr, sat, ph);
    check({tag, ".score"}, sc, 0);  check({tag, ".combo"}, cb, 0);
    check({tag, ".maxc"}, mc, 0);   check({tag, ".high"}, hs, 0);
    check({tag, ".newrec"}, nr, 0); check({tag, ".sat"}, sat, 0);
    check({tag, ".phase"}, ph, 0);
  endtask

  task automatic check_model(input int k);
    longint sc, cb, mc, hs, nr, sat, ph;
    string  t;
    t = $sformatf("rnd%0d@%0d", k, ecnt);
    get_out(k, sc, cb, mc, hs, nr, sat, ph);
    check({t, ".score"}, sc, m_score[k]);  check({t, ".combo"}, cb, m_combo[k]);
    check({t, ".maxc"}, mc, m_maxc[k]);    check({t, ".high"}, hs, m_high[k]);
    check({t, ".newrec"}, nr, m_nr[k]);    check({t, ".sat"}, sat, m_sat[k]);
    check({t, ".phase"}, ph, m_phase[k]);
  endtask

  typedef struct {
    int st, en, hv, g;
    int score, combo, maxc, high, nr, ph;
  } vec_t;

  vec_t tbl[17];

  initial begin
    longint sc, cb, mc, hs, nr, sat, ph;

    tbl[0]  = '{0,0,1,3,    0,0,0,   0,0,0};
    tbl[1]  = '{1,0,0,0,    0,0,0,   0,0,1};
    tbl[2]  = '{0,0,1,3,    0,1,1,   0,0,1};
    tbl[3]  = '{0,0,1,3,  300,2,2,   0,0,1};
    tbl[4]  = '{0,0,1,3,  600,3,3,   0,0,1};
    tbl[5]  = '{0,0,0,0,  900,3,3,   0,0,1};
    tbl[6]  = '{0,0,1,0,  900,0,3,   0,0,1};
    tbl[7]  = '{0,0,1,1,  900,1,3,   0,0,1};
    tbl[8]  = '{0,1,1,2, 1000,2,3,   0,0,2};
    tbl[9]  = '{0,0,0,0, 1200,2,3,   0,0,2};
    tbl[10] = '{0,0,0,0, 1200,2,3,   0,0,2};
    tbl[11] = '{0,0,0,0, 1200,2,3,1200,1,2};
    tbl[12] = '{1,1,0,0,    0,0,0,1200,0,1};
    tbl[13] = '{0,1,0,0,    0,0,0,1200,0,2};
    tbl[14] = '{0,0,0,0,    0,0,0,1200,0,2};
    tbl[15] = '{0,1,0,0,    0,0,0,1200,0,2};
    tbl[16] = '{1,0,0,0,    0,0,0,1200,0,1};

    if1.GAME_START = 1'b0; if1.GAME_END = 1'b0; if1.HIT_VALID = 1'b0; if1.HIT_GRADE = 2'd0;
    if2.GAME_START = 1'b0; if2.GAME_END = 1'b0; if2.HIT_VALID = 1'b0; if2.HIT_GRADE = 2'd0;
    model_reset();
    repeat (3) @(posedge CLK);
    #1;
    check_zero("reset1", 0);
    check_zero("reset2", 1);
    @(negedge CLK);
    RST = 1'b1;

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].st, tbl[i].en, tbl[i].hv, tbl[i].g);
      get_out(0, sc, cb, mc, hs, nr, sat, ph);
      check($sformatf("vec%0d.score", i), sc, tbl[i].score);
      check($sformatf("vec%0d.combo", i), cb, tbl[i].combo);
      check($sformatf("vec%0d.maxc", i), mc, tbl[i].maxc);
      check($sformatf("vec%0d.high", i), hs, tbl[i].high);
      check($sformatf("vec%0d.newrec", i), nr, tbl[i].nr);
      check($sformatf("vec%0d.phase", i), ph, tbl[i].ph);
    end

    // Multiplier steps at every 10 combo and is capped at 4.
    drive(1, 0, 0, 0);
    repeat (10) drive(0, 0, 1, 3);
    drive(0, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 0);
    check("mult.score11", if1.BINARY_SCORE, 3200);
    check("mult.combo11", if1.COMBO, 11);
    repeat (40) drive(0, 0, 1, 3);
    repeat (2) drive(0, 0, 0, 0);
    check("mult.score51", if1.BINARY_SCORE, 42800);
    check("mult.combo51", if1.COMBO, 51);
    check("mult.maxc51", if1.MAX_COMBO, 51);

    // A miss breaks the combo but MAX_COMBO keeps the run.
    drive(1, 0, 0, 0);
    repeat (5) drive(0, 0, 1, 2);
    drive(0, 0, 1, 0);
    repeat (2) drive(0, 0, 1, 1);
    repeat (2) drive(0, 0, 0, 0);
    check("miss.score", if1.BINARY_SCORE, 1200);
    check("miss.combo", if1.COMBO, 2);
    check("miss.maxc", if1.MAX_COMBO, 5);

    // Small ceiling instance clamps the fourth PERFECT.
    drive(1, 0, 0, 0);
    drive(0, 0, 1, 3);
    drive(0, 0, 1, 3);
    check("sat.s1", if2.BINARY_SCORE, 300);
    drive(0, 0, 1, 3);
    check("sat.s2", if2.BINARY_SCORE, 600);
    drive(0, 0, 1, 3);
    check("sat.s3", if2.BINARY_SCORE, 900);
    check("sat.flag0", if2.SATURATED, 0);
    drive(0, 0, 0, 0);
    check("sat.s4", if2.BINARY_SCORE, 1000);
    check("sat.flag1", if2.SATURATED, 1);

    // Mid-game reset clears everything, HIGH_SCORE included, without a clock edge.
    check("pre_rst.high", if1.HIGH_SCORE, 1200);
    drive(0, 0, 1, 3);
    @(negedge CLK);
    if1.HIT_VALID = 1'b0; if2.HIT_VALID = 1'b0;
    RST = 1'b0;
    #1;
    check_zero("midrst1", 0);
    check_zero("midrst2", 1);
    model_reset();
    @(negedge CLK);
    RST = 1'b1;

    // End in the same cycle as a hit: the hit commits, then the record is taken.
    drive(1, 0, 0, 0);
    drive(0, 1, 1, 3);
    drive(0, 0, 0, 0);
    check("end.score", if1.BINARY_SCORE, 300);
    check("end.phase", if1.PHASE, 2);
    for (int i = 0; i < 6 && if1.NEW_RECORD !== 1'b1; i++) drive(0, 0, 0, 0);
    check("end.newrec", if1.NEW_RECORD, 1);
    check("end.high", if1.HIGH_SCORE, 300);
    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    repeat (3) drive(0, 0, 0, 0);
    check("empty.high", if1.HIGH_SCORE, 300);
    check("empty.newrec", if1.NEW_RECORD, 0);
    check("empty.phase", if1.PHASE, 2);

    // Random play against the model on both ceilings.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom % 40) == 0 ? 1 : 0, ($urandom % 30) == 0 ? 1 : 0,
            ($urandom % 4) != 0 ? 1 : 0, int'($urandom % 4));
      check_model(0);
      check_model(1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
